// File: rtl/conv_channel_sched.sv
// Time-multiplexes one shared per-channel conv engine across the input channels of an output pixel,
// accumulating the returned partial sums and handing the total downstream via valid/ready.
module conv_channel_sched #(
  parameter int BIT_WIDTH   = 8,
  parameter int OUT_WIDTH   = 8,
  parameter int KERNEL_SIZE = 5,
  parameter int CHANNEL     = 3,
  parameter int ENGINE_LAT  = 2,
  localparam int CH_W  = (CHANNEL > 1) ? $clog2(CHANNEL) : 1,
  localparam int CNT_W = $clog2(CHANNEL + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_valid,
  output logic                 start_ready,
  input  logic [CNT_W-1:0]     cfg_nch,
  output logic                 eng_issue,
  output logic [CH_W-1:0]      eng_ch,
  input  logic [OUT_WIDTH-1:0] eng_result,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] conv_value,
  output logic                 busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [CNT_W-1:0] NCH_MAX = CNT_W'(CHANNEL);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  if (CHANNEL < 1 || CHANNEL > 16 || ENGINE_LAT < 0 || ENGINE_LAT > 4 ||
      BIT_WIDTH < 1 || KERNEL_SIZE < 1 || OUT_WIDTH < 1) begin : g_param_check
    $error("conv_channel_sched: illegal parameter combination");
  end

  logic [1:0]           state_q, state_d;
  logic [CNT_W-1:0]     nch_q, nch_d;
  logic [CNT_W-1:0]     issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0]     res_cnt_q, res_cnt_d;
  logic [OUT_WIDTH-1:0] acc_q, acc_d;
  logic [OUT_WIDTH-1:0] conv_q, conv_d;
  logic [CNT_W-1:0]     nch_clamped;
  logic                 capture;

  assign start_ready = (state_q == S_IDLE);
  assign busy        = (state_q != S_IDLE);
  assign out_valid   = (state_q == S_DONE);
  assign eng_issue   = (state_q == S_ISSUE);
  assign eng_ch      = eng_issue ? issue_cnt_q[CH_W-1:0] : '0;
  assign conv_value  = conv_q;

  assign nch_clamped = (cfg_nch == '0 || cfg_nch > NCH_MAX) ? NCH_MAX : cfg_nch;

  // The delayed issue bit marks the cycle in which eng_result belongs to this job.
  if (ENGINE_LAT == 0) begin : g_comb_engine
    assign capture = eng_issue;
  end else begin : g_pipe
    logic [ENGINE_LAT-1:0] pipe_q;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) pipe_q[0] <= 1'b0;
      else     pipe_q[0] <= eng_issue;
    end
    for (genvar gi = 1; gi < ENGINE_LAT; gi++) begin : g_stage
      always_ff @(posedge clk or posedge rst) begin
        if (rst) pipe_q[gi] <= 1'b0;
        else     pipe_q[gi] <= pipe_q[gi-1];
      end
    end
    assign capture = pipe_q[ENGINE_LAT-1];
  end

  always_comb begin
    state_d     = state_q;
    nch_d       = nch_q;
    issue_cnt_d = issue_cnt_q;
    res_cnt_d   = capture ? (res_cnt_q + ONE) : res_cnt_q;
    acc_d       = capture ? (acc_q + eng_result) : acc_q;
    conv_d      = conv_q;
    case (state_q)
      S_IDLE: begin
        if (start_valid) begin
          nch_d       = nch_clamped;
          issue_cnt_d = '0;
          res_cnt_d   = '0;
          acc_d       = '0;
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        issue_cnt_d = issue_cnt_q + ONE;
        if (issue_cnt_q + ONE == nch_q) state_d = S_DRAIN;
        // A combinational engine finishes on the last issue cycle, skipping DRAIN.
        if (res_cnt_d == nch_q) begin
          state_d = S_DONE;
          conv_d  = acc_d;
        end
      end
      S_DRAIN: begin
        if (res_cnt_d == nch_q) begin
          state_d = S_DONE;
          conv_d  = acc_d;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      nch_q       <= '0;
      issue_cnt_q <= '0;
      res_cnt_q   <= '0;
      acc_q       <= '0;
      conv_q      <= '0;
    end else begin
      state_q     <= state_d;
      nch_q       <= nch_d;
      issue_cnt_q <= issue_cnt_d;
      res_cnt_q   <= res_cnt_d;
      acc_q       <= acc_d;
      conv_q      <= conv_d;
    end
  end

endmodule

// File: tb/tb_conv_channel_sched.sv
// Drives two scheduler builds (ENGINE_LAT=2 and ENGINE_LAT=0) with random jobs and checks
// issue sequence, output timing and channel sums against a per-job reference.
module tb_conv_channel_sched;
  localparam int CH = 3;

  logic       clk;
  logic       rst;
  logic       start_valid [2];
  logic       start_ready [2];
  logic [1:0] cfg_nch     [2];
  logic       eng_issue   [2];
  logic [1:0] eng_ch      [2];
  logic [7:0] eng_result  [2];
  logic       out_valid   [2];
  logic       out_ready   [2];
  logic [7:0] conv_value  [2];
  logic       busy        [2];

  logic [7:0] vals [2][4];
  logic [7:0] junk;
  logic       iss_h1, iss_h2;
  logic [1:0] ch_h1, ch_h2;

  int n_tests = 0;
  int n_fail  = 0;

  conv_channel_sched #(.BIT_WIDTH(8), .OUT_WIDTH(8), .KERNEL_SIZE(5), .CHANNEL(CH), .ENGINE_LAT(2)) u_dut_lat2 (
    .clk(clk), .rst(rst),
    .start_valid(start_valid[0]), .start_ready(start_ready[0]), .cfg_nch(cfg_nch[0]),
    .eng_issue(eng_issue[0]), .eng_ch(eng_ch[0]), .eng_result(eng_result[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .conv_value(conv_value[0]), .busy(busy[0])
  );

  conv_channel_sched #(.BIT_WIDTH(8), .OUT_WIDTH(8), .KERNEL_SIZE(5), .CHANNEL(CH), .ENGINE_LAT(0)) u_dut_lat0 (
    .clk(clk), .rst(rst),
    .start_valid(start_valid[1]), .start_ready(start_ready[1]), .cfg_nch(cfg_nch[1]),
    .eng_issue(eng_issue[1]), .eng_ch(eng_ch[1]), .eng_result(eng_result[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .conv_value(conv_value[1]), .busy(busy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Engine models: two-cycle delayed table lookup, and a combinational one. Garbage otherwise.
  always_ff @(posedge clk) begin
    iss_h1 <= eng_issue[0];
    ch_h1  <= eng_ch[0];
    iss_h2 <= iss_h1;
    ch_h2  <= ch_h1;
    junk   <= 8'($urandom);
  end

  always_comb begin
    eng_result[0] = iss_h2 ? vals[0][ch_h2] : junk;
    eng_result[1] = eng_issue[1] ? vals[1][eng_ch[1]] : junk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_reset_state(input int d);
    check("rst_start_ready", 32'(start_ready[d]), 1);
    check("rst_eng_issue",   32'(eng_issue[d]),   0);
    check("rst_eng_ch",      32'(eng_ch[d]),      0);
    check("rst_out_valid",   32'(out_valid[d]),   0);
    check("rst_conv_value",  32'(conv_value[d]),  0);
    check("rst_busy",        32'(busy[d]),        0);
  endtask

  // Called at the falling edge of an idle cycle; returns at the falling edge of the next idle cycle.
  task automatic run_job(input int d, input int cfg, input int stall, input bit hold);
    int n, lat, sum;
    logic [7:0] exp;
    lat = (d == 0) ? 2 : 0;
    n   = (cfg == 0 || cfg > CH) ? CH : cfg;
    sum = 0;
    for (int i = 0; i < n; i++) sum += int'(vals[d][i]);
    exp = 8'(sum % 256);
    cfg_nch[d]     = 2'(cfg);
    start_valid[d] = 1'b1;
    out_ready[d]   = 1'b1;
    check("start_ready_idle", 32'(start_ready[d]), 1);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (!hold) start_valid[d] = 1'b0;
      check("issue",       32'(eng_issue[d]),   1);
      check("issue_ch",    32'(eng_ch[d]),      32'(k));
      check("issue_busy",  32'(busy[d]),        1);
      check("issue_valid", 32'(out_valid[d]),   0);
      check("issue_ready", 32'(start_ready[d]), 0);
    end
    for (int k = 0; k < lat; k++) begin
      @(negedge clk);
      check("drain_issue", 32'(eng_issue[d]), 0);
      check("drain_valid", 32'(out_valid[d]), 0);
      check("drain_busy",  32'(busy[d]),      1);
    end
    @(negedge clk);
    check("done_valid", 32'(out_valid[d]),   1);
    check("done_value", 32'(conv_value[d]),  32'(exp));
    check("done_issue", 32'(eng_issue[d]),   0);
    check("done_busy",  32'(busy[d]),        1);
    check("done_ready", 32'(start_ready[d]), 0);
    if (stall > 0) begin
      out_ready[d] = 1'b0;
      for (int s = 0; s < stall; s++) begin
        @(negedge clk);
        check("stall_valid", 32'(out_valid[d]),   1);
        check("stall_value", 32'(conv_value[d]),  32'(exp));
        check("stall_ready", 32'(start_ready[d]), 0);
        check("stall_issue", 32'(eng_issue[d]),   0);
      end
      out_ready[d] = 1'b1;
    end
    @(negedge clk);
    check("post_valid", 32'(out_valid[d]),   0);
    check("post_ready", 32'(start_ready[d]), 1);
    check("post_value", 32'(conv_value[d]),  32'(exp));
    check("post_busy",  32'(busy[d]),        0);
    $display("[TB] dut%0d job nch_cfg=%0d n=%0d stall=%0d expected=%0d", d, cfg, n, stall, exp);
  endtask

  task automatic load_vals(input int d, input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    vals[d][0] = a;
    vals[d][1] = b;
    vals[d][2] = c;
    vals[d][3] = 8'($urandom);
  endtask

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      start_valid[d] = 1'b0;
      cfg_nch[d]     = 2'd0;
      out_ready[d]   = 1'b1;
      for (int i = 0; i < 4; i++) vals[d][i] = 8'd0;
    end
    @(negedge clk);
    @(negedge clk);
    check_reset_state(0);
    check_reset_state(1);
    rst = 1'b0;
    @(negedge clk);

    load_vals(0, 8'd10, 8'd20, 8'd30);
    run_job(0, 3, 0, 1'b0);
    load_vals(0, 8'd200, 8'd100, 8'd0);
    run_job(0, 3, 0, 1'b0);

    // Back-to-back: start_valid stays high through the stall into the next job.
    load_vals(0, 8'($urandom), 8'($urandom), 8'($urandom));
    run_job(0, 3, 5, 1'b1);
    load_vals(0, 8'd7, 8'($urandom), 8'($urandom));
    run_job(0, 1, 0, 1'b0);
    load_vals(0, 8'($urandom), 8'($urandom), 8'($urandom));
    run_job(0, 0, 0, 1'b0);

    // Abort a job in its second issue cycle.
    load_vals(0, 8'd90, 8'd91, 8'd92);
    cfg_nch[0]     = 2'd3;
    start_valid[0] = 1'b1;
    @(negedge clk);
    start_valid[0] = 1'b0;
    @(negedge clk);
    check("abort_issue_ch", 32'(eng_ch[0]), 1);
    rst = 1'b1;
    #1;
    check_reset_state(0);
    @(negedge clk);
    rst = 1'b0;
    load_vals(0, 8'd1, 8'd2, 8'd3);
    run_job(0, 3, 0, 1'b0);

    load_vals(1, 8'd5, 8'd6, 8'd7);
    run_job(1, 3, 0, 1'b0);
    load_vals(1, 8'd7, 8'($urandom), 8'($urandom));
    run_job(1, 1, 2, 1'b0);

    for (int d = 0; d < 2; d++) begin
      for (int j = 0; j < 25; j++) begin
        load_vals(d, 8'($urandom), 8'($urandom), 8'($urandom));
        run_job(d, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                (j != 24) ? 1'($urandom_range(0, 1)) : 1'b0);
      end
      start_valid[d] = 1'b0;
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
